// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared state encoding and default sizes for adder_arbiter
package adder_arbiter_pkg;

    localparam int DEFAULT_N       = 8;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GET  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter2.sv
// rtl/adder_arbiter_rr_arbiter2.sv - two-way round-robin grant, pointer advances on accept
module rr_arbiter2
    import adder_arbiter_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_any,
    output logic       o_idx
);

    logic r_prio;
    logic w_idx;

    // Contention resolves to the pointer; a lone requester always wins.
    assign w_idx = (i_req == 2'b11) ? r_prio : i_req[1];
    assign o_any = |i_req;
    assign o_idx = w_idx;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_prio <= 1'b0;
        end else if (i_accept && o_any) begin
            r_prio <= ~w_idx;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one external adder between two requesters, one op in flight
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [N-1:0]   resp_data,
    output logic           resp_err,
    output logic [N-1:0]   adder_data1,
    output logic [N-1:0]   adder_data2,
    output logic           adder_set1,
    output logic           adder_set2,
    output logic           adder_get,
    input  logic [N-1:0]   adder_sum,
    input  logic           adder_sum_valid
);

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic         r_gnt;
    logic [7:0]   r_cnt;
    logic [N-1:0] r_resp_data;
    logic         r_resp_err;

    logic         w_any;
    logic         w_idx;
    logic         w_accept;
    logic         w_timeout;
    logic         w_resp_taken;

    rr_arbiter2 u_rr (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_any    (w_any),
        .o_idx    (w_idx)
    );

    // Reset suppresses the grant so no request is acknowledged and then lost.
    assign w_accept     = (r_state == S_IDLE) && w_any && !reset;
    assign w_timeout    = (r_cnt == LP_CNT_LAST);
    assign w_resp_taken = r_gnt ? resp_ready[1] : resp_ready[0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_LOAD;
            S_LOAD: w_state_next = S_GET;
            S_GET:  w_state_next = S_WAIT;
            S_WAIT: if (adder_sum_valid || w_timeout) w_state_next = S_RESP;
            S_RESP: if (w_resp_taken) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt  <= w_idx;
                        r_op_a <= w_idx ? req_a[2*N-1:N] : req_a[N-1:0];
                        r_op_b <= w_idx ? req_b[2*N-1:N] : req_b[N-1:0];
                    end
                end
                S_GET: r_cnt <= '0;
                S_WAIT: begin
                    if (adder_sum_valid) begin
                        r_resp_data <= adder_sum;
                        r_resp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_accept ? {w_idx, ~w_idx} : 2'b00;
    assign resp_valid  = (r_state == S_RESP) ? {r_gnt, ~r_gnt} : 2'b00;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;
    assign adder_data1 = r_op_a;
    assign adder_data2 = r_op_b;
    assign adder_set1  = (r_state == S_LOAD);
    assign adder_set2  = (r_state == S_LOAD);
    assign adder_get   = (r_state == S_GET);

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N, default 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 15, max cycles waited for adder_sum_valid; legal range 1..255.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-006 req_ready  output  2  per-requester request accepted, bit i = requester i.
REQ-007 req_a  input  2*N  operand A, requester i at bits [i*N +: N].
REQ-008 req_b  input  2*N  operand B, same packing as req_a.
REQ-009 resp_valid  output  2  per-requester response valid.
REQ-010 resp_ready  input  2  per-requester response accepted.
REQ-011 resp_data  output  N  result to the granted requester.
REQ-012 resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-013 adder_data1, adder_data2  output  N each  operands to the shared adder.
REQ-014 adder_set1, adder_set2, adder_get  output  1 each  adder load/read strobes.
REQ-015 adder_sum  input  N  adder result; adder_sum_valid  input  1  result qualifier.

Function
REQ-016 FSM states IDLE, LOAD, GET, WAIT, RESP; only one operation in flight.
REQ-017 IDLE: if any req_valid, grant by round-robin; go to LOAD next cycle.
REQ-018 Round-robin: on contention, grant the requester not granted last; after reset, requester 0 has priority.
REQ-019 req_ready[g] is high for exactly one cycle, the IDLE cycle of the grant; operands captured that cycle.
REQ-020 LOAD: adder_set1=adder_set2=1 for one cycle with captured operands on adder_data1/2.
REQ-021 GET: adder_get=1 for one cycle; go to WAIT.
REQ-022 WAIT: count cycles; on adder_sum_valid capture adder_sum into resp_data, resp_err=0, go RESP.
REQ-023 WAIT: if TIMEOUT cycles elapse without adder_sum_valid, resp_data=0, resp_err=1, go RESP.
REQ-024 adder_sum_valid in any state other than WAIT is ignored.
REQ-025 RESP: resp_valid[g] held high, resp_data/resp_err stable, until resp_ready[g]; then IDLE.
REQ-026 resp_ready of the non-granted requester is ignored; resp_valid is never high on both bits.
REQ-027 Strobes and req_ready are 0 outside their states; adder_data1/2 hold last operands.
REQ-028 Minimum request-to-response latency: 4 cycles (grant, LOAD, GET, WAIT with immediate valid); back-to-back ops need one IDLE cycle.
REQ-029 Result width N; carry discarded (e.g. N=8: 0xFF+0x01 -> 0x00).

Reset
REQ-030 reset asserted: next state IDLE, all outputs 0, timeout counter 0, round-robin pointer to requester 0.
REQ-031 reset mid-operation aborts the op with no response; a pending strobe is dropped the same edge.

Structure
REQ-032 Shared package holds FSM state encoding and default N/TIMEOUT constants.
REQ-033 One sub-module: rr_arbiter2 (2-way round-robin grant with pointer update on accept).

Verification
REQ-034 Single req0 a=3,b=4, adder returns 7 one cycle after get -> resp_valid[0] with 7, resp_err=0, 4-cycle latency.
REQ-035 req0 and req1 both valid continuously -> grants alternate 0,1,0,1.
REQ-036 Adder never asserts adder_sum_valid, TIMEOUT=15 -> resp_err=1, resp_data=0 after exactly 15 WAIT cycles.
REQ-037 resp_ready held low 10 cycles -> resp_valid and data held stable; no new grant until accept.
REQ-038 reset asserted during WAIT -> next cycle all outputs 0, no response; new req1 then granted normally.
REQ-039 N=8, a=0xFF,b=0x01, adder model returns 0x00 -> resp_data=0x00, resp_err=0.
